// File: rtl/robo_pkg.sv
// Shared maze constants, direction bit positions and mover state encoding.
// Used by the limiter, mover, draw and collision stages.
package robo_pkg;

  localparam int unsigned GRID_W  = 160;
  localparam int unsigned GRID_H  = 120;
  localparam int unsigned X_W     = 8;
  localparam int unsigned Y_W     = 7;
  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned START_X = 1;
  localparam int unsigned START_Y = 1;

  localparam int unsigned DIR_W     = 4;
  localparam int unsigned DIR_UP    = 3;
  localparam int unsigned DIR_DOWN  = 2;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_RIGHT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CHECK = 2'd2
  } mover_state_e;

endpackage

// File: rtl/cell_addr.sv
// Row-major maze cell address: y*GRID_W + x.
// Shared with the VGA draw stage so both see the same wall-map layout.
module cell_addr
  import robo_pkg::*;
(
  input  logic [X_W-1:0]    i_x,
  input  logic [Y_W-1:0]    i_y,
  output logic [ADDR_W-1:0] o_addr
);

  assign o_addr = (ADDR_W'(i_y) * ADDR_W'(GRID_W)) + ADDR_W'(i_x);

endmodule

// File: rtl/robot_mover.sv
// Robot position owner: on a rate tick, tries a one-cell move and
// consults the 1-cycle-latency wall ROM before committing it.
module robot_mover
  import robo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic [DIR_W-1:0]  dir,
  output logic [ADDR_W-1:0] map_addr,
  input  logic              map_data,
  output logic [X_W-1:0]    pos_x,
  output logic [Y_W-1:0]    pos_y,
  output logic              busy,
  output logic              moved,
  output logic              blocked
);

  mover_state_e      r_state;
  logic [X_W-1:0]    r_pos_x;
  logic [Y_W-1:0]    r_pos_y;
  logic [X_W-1:0]    r_tx;
  logic [Y_W-1:0]    r_ty;
  logic [ADDR_W-1:0] r_map_addr;
  logic              r_busy;
  logic              r_moved;
  logic              r_blocked;

  logic              w_one_hot;
  logic              w_edge;
  logic [X_W-1:0]    w_tx;
  logic [Y_W-1:0]    w_ty;
  logic [ADDR_W-1:0] w_addr;

  assign w_one_hot = (dir != '0) && ((dir & (dir - DIR_W'(1))) == '0);

  // Target cell and grid-edge test; only meaningful when dir is one-hot.
  always_comb begin
    w_tx   = r_pos_x;
    w_ty   = r_pos_y;
    w_edge = 1'b0;
    if (dir[DIR_UP]) begin
      w_edge = (r_pos_y == '0);
      w_ty   = r_pos_y - Y_W'(1);
    end else if (dir[DIR_DOWN]) begin
      w_edge = (r_pos_y == Y_W'(GRID_H - 1));
      w_ty   = r_pos_y + Y_W'(1);
    end else if (dir[DIR_LEFT]) begin
      w_edge = (r_pos_x == '0);
      w_tx   = r_pos_x - X_W'(1);
    end else if (dir[DIR_RIGHT]) begin
      w_edge = (r_pos_x == X_W'(GRID_W - 1));
      w_tx   = r_pos_x + X_W'(1);
    end
  end

  cell_addr u_cell_addr (
    .i_x    (w_tx),
    .i_y    (w_ty),
    .o_addr (w_addr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pos_x    <= X_W'(START_X);
      r_pos_y    <= Y_W'(START_Y);
      r_tx       <= '0;
      r_ty       <= '0;
      r_map_addr <= '0;
      r_busy     <= 1'b0;
      r_moved    <= 1'b0;
      r_blocked  <= 1'b0;
    end else begin
      r_moved   <= 1'b0;
      r_blocked <= 1'b0;
      case (r_state)
        IDLE: begin
          if (tick && w_one_hot) begin
            if (w_edge) begin
              r_blocked <= 1'b1;
            end else begin
              r_tx       <= w_tx;
              r_ty       <= w_ty;
              r_map_addr <= w_addr;
              r_busy     <= 1'b1;
              r_state    <= FETCH;
            end
          end
        end
        // ROM samples r_map_addr at the end of this cycle.
        FETCH: r_state <= CHECK;
        CHECK: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
          if (map_data) begin
            r_blocked <= 1'b1;
          end else begin
            r_pos_x <= r_tx;
            r_pos_y <= r_ty;
            r_moved <= 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign map_addr = r_map_addr;
  assign pos_x    = r_pos_x;
  assign pos_y    = r_pos_y;
  assign busy     = r_busy;
  assign moved    = r_moved;
  assign blocked  = r_blocked;

endmodule

// File: tb/tb_robot_mover.sv
// Directed bench for robot_mover with a one-wall synchronous ROM model.
module tb_robot_mover;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  dir = 4'b0000;
  logic [14:0] map_addr;
  logic        map_data = 1'b0;
  logic [7:0]  pos_x;
  logic [6:0]  pos_y;
  logic        busy;
  logic        moved;
  logic        blocked;

  logic [14:0] wall_addr = 15'h7FFF;
  int vectors = 0;
  int miscompares = 0;

  robot_mover dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .dir      (dir),
    .map_addr (map_addr),
    .map_data (map_data),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .busy     (busy),
    .moved    (moved),
    .blocked  (blocked)
  );

  always #5 clock = ~clock;

  // Synchronous wall ROM: a single wall cell at wall_addr.
  always @(posedge clock) map_data <= (map_addr == wall_addr);

  // Stimulus-only helper: one tick then wait for the move to settle.
  task automatic step(input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock); tick = 1'b1; dir = d;
      @(negedge clock); tick = 1'b0; dir = 4'b0000;
      repeat (3) @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b1; dir = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); @(negedge clock);
      vectors++;
      if ({pos_x, pos_y} !== {8'd1, 7'd1}) begin
        miscompares++; $display("FAIL reset_pos c%0d: got (%0d,%0d) expected (1,1)", c, pos_x, pos_y);
      end
      vectors++;
      if ({busy, moved, blocked} !== 3'b000) begin
        miscompares++; $display("FAIL reset_flags c%0d: got %b expected 000", c, {busy, moved, blocked});
      end
      vectors++;
      if (map_addr !== 15'd0) begin
        miscompares++; $display("FAIL reset_addr c%0d: got %0d expected 0", c, map_addr);
      end
    end
    reset = 1'b0; tick = 1'b0; dir = 4'b0000;
  endtask

  task automatic test_move_right();
    step(4'b0001, 9);
    step(4'b0100, 9);
    vectors++;
    if ({pos_x, pos_y} !== {8'd10, 7'd10}) begin
      miscompares++; $display("FAIL travel_10_10: got (%0d,%0d) expected (10,10)", pos_x, pos_y);
    end
    @(negedge clock); tick = 1'b1; dir = 4'b0001;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock); tick = 1'b0; dir = 4'b1000;
      vectors++;
      if (map_addr !== 15'd1611 || busy !== 1'b1) begin
        miscompares++; $display("FAIL right_fetch T+%0d: got addr %0d busy %b expected 1611 1", c, map_addr, busy);
      end
      vectors++;
      if ({pos_x, pos_y, moved, blocked} !== {8'd10, 7'd10, 2'b00}) begin
        miscompares++; $display("FAIL right_hold T+%0d: got (%0d,%0d) m%b b%b expected (10,10) m0 b0", c, pos_x, pos_y, moved, blocked);
      end
    end
    @(negedge clock); dir = 4'b0000;
    vectors++;
    if ({pos_x, pos_y, moved, blocked, busy} !== {8'd11, 7'd10, 3'b100}) begin
      miscompares++; $display("FAIL right_done: got (%0d,%0d) m%b b%b busy%b expected (11,10) m1 b0 busy0", pos_x, pos_y, moved, blocked, busy);
    end
    @(negedge clock);
    vectors++;
    if ({pos_x, pos_y, moved} !== {8'd11, 7'd10, 1'b0}) begin
      miscompares++; $display("FAIL right_pulse_len: got (%0d,%0d) m%b expected (11,10) m0", pos_x, pos_y, moved);
    end
  endtask

  task automatic test_wall_up();
    step(4'b0010, 1);
    wall_addr = 15'd1450;
    @(negedge clock); tick = 1'b1; dir = 4'b1000;
    @(negedge clock); tick = 1'b0; dir = 4'b0000;
    vectors++;
    if (map_addr !== 15'd1450 || busy !== 1'b1) begin
      miscompares++; $display("FAIL up_fetch: got addr %0d busy %b expected 1450 1", map_addr, busy);
    end
    repeat (2) @(negedge clock);
    vectors++;
    if ({pos_x, pos_y, moved, blocked, busy} !== {8'd10, 7'd10, 3'b010}) begin
      miscompares++; $display("FAIL up_wall: got (%0d,%0d) m%b b%b busy%b expected (10,10) m0 b1 busy0", pos_x, pos_y, moved, blocked, busy);
    end
    @(negedge clock);
    vectors++;
    if (blocked !== 1'b0) begin
      miscompares++; $display("FAIL up_wall_len: got blocked %b expected 0", blocked);
    end
    wall_addr = 15'h7FFF;
  endtask

  task automatic test_edge_left();
    step(4'b0010, 10);
    step(4'b1000, 5);
    vectors++;
    if ({pos_x, pos_y, map_addr} !== {8'd0, 7'd5, 15'd800}) begin
      miscompares++; $display("FAIL travel_0_5: got (%0d,%0d) addr %0d expected (0,5) 800", pos_x, pos_y, map_addr);
    end
    @(negedge clock); tick = 1'b1; dir = 4'b0010;
    @(negedge clock); tick = 1'b0; dir = 4'b0000;
    vectors++;
    if ({blocked, busy, moved, map_addr} !== {3'b100, 15'd800}) begin
      miscompares++; $display("FAIL left_edge: got b%b busy%b m%b addr %0d expected b1 busy0 m0 800", blocked, busy, moved, map_addr);
    end
    @(negedge clock); tick = 1'b1; dir = 4'b0000;
    @(negedge clock); tick = 1'b0;
    vectors++;
    if ({blocked, busy, moved, pos_x, pos_y} !== {3'b000, 8'd0, 7'd5}) begin
      miscompares++; $display("FAIL dir_zero: got b%b busy%b m%b (%0d,%0d) expected 000 (0,5)", blocked, busy, moved, pos_x, pos_y);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock); tick = 1'b1; dir = 4'b0001;
    @(negedge clock);
    vectors++;
    if (map_addr !== 15'd801 || busy !== 1'b1) begin
      miscompares++; $display("FAIL b2b_first_addr: got %0d busy %b expected 801 1", map_addr, busy);
    end
    @(negedge clock);
    vectors++;
    if (map_addr !== 15'd801 || moved !== 1'b0) begin
      miscompares++; $display("FAIL b2b_dropped: got addr %0d m%b expected 801 m0", map_addr, moved);
    end
    @(negedge clock);
    vectors++;
    if ({pos_x, pos_y, moved} !== {8'd1, 7'd5, 1'b1}) begin
      miscompares++; $display("FAIL b2b_first_done: got (%0d,%0d) m%b expected (1,5) m1", pos_x, pos_y, moved);
    end
    @(negedge clock); tick = 1'b0; dir = 4'b0000;
    vectors++;
    if ({map_addr, busy, moved} !== {15'd802, 2'b10}) begin
      miscompares++; $display("FAIL b2b_second_start: got addr %0d busy%b m%b expected 802 busy1 m0", map_addr, busy, moved);
    end
    repeat (2) @(negedge clock);
    vectors++;
    if ({pos_x, pos_y, moved} !== {8'd2, 7'd5, 1'b1}) begin
      miscompares++; $display("FAIL b2b_second_done: got (%0d,%0d) m%b expected (2,5) m1", pos_x, pos_y, moved);
    end
    @(negedge clock);
  endtask

  task automatic test_far_corner();
    step(4'b0001, 157);
    step(4'b0100, 114);
    vectors++;
    if ({pos_x, pos_y, map_addr} !== {8'd159, 7'd119, 15'd19199}) begin
      miscompares++; $display("FAIL travel_corner: got (%0d,%0d) addr %0d expected (159,119) 19199", pos_x, pos_y, map_addr);
    end
    @(negedge clock); tick = 1'b1; dir = 4'b0101;
    @(negedge clock); tick = 1'b0; dir = 4'b0000;
    vectors++;
    if ({busy, moved, blocked} !== 3'b000) begin
      miscompares++; $display("FAIL two_bit_dir: got busy%b m%b b%b expected 000", busy, moved, blocked);
    end
    @(negedge clock); tick = 1'b1; dir = 4'b0001;
    @(negedge clock); tick = 1'b1; dir = 4'b0100;
    vectors++;
    if ({blocked, busy} !== 2'b10) begin
      miscompares++; $display("FAIL right_edge: got b%b busy%b expected b1 busy0", blocked, busy);
    end
    @(negedge clock); tick = 1'b0; dir = 4'b0000;
    vectors++;
    if ({blocked, busy, pos_x, pos_y, map_addr} !== {2'b10, 8'd159, 7'd119, 15'd19199}) begin
      miscompares++; $display("FAIL down_edge: got b%b busy%b (%0d,%0d) addr %0d expected b1 busy0 (159,119) 19199", blocked, busy, pos_x, pos_y, map_addr);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_move();
    @(negedge clock); tick = 1'b1; dir = 4'b0010;
    @(negedge clock); tick = 1'b0; dir = 4'b0000;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    vectors++;
    if ({pos_x, pos_y, moved, blocked, busy, map_addr} !== {8'd1, 7'd1, 3'b000, 15'd0}) begin
      miscompares++; $display("FAIL reset_mid_move: got (%0d,%0d) m%b b%b busy%b addr %0d expected (1,1) 000 0", pos_x, pos_y, moved, blocked, busy, map_addr);
    end
    repeat (2) @(negedge clock);
    vectors++;
    if ({moved, blocked} !== 2'b00) begin
      miscompares++; $display("FAIL reset_no_late_pulse: got m%b b%b expected 00", moved, blocked);
    end
    step(4'b0001, 1);
    vectors++;
    if ({pos_x, pos_y, map_addr} !== {8'd2, 7'd1, 15'd162}) begin
      miscompares++; $display("FAIL after_reset_move: got (%0d,%0d) addr %0d expected (2,1) 162", pos_x, pos_y, map_addr);
    end
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_wall_up();
    test_edge_left();
    test_back_to_back();
    test_far_corner();
    test_reset_mid_move();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/robot_mover.md
Name: robot_mover

Overview:
- Consumes the one-cycle rate tick produced by the clock limiter. On each accepted tick it attempts a one-cell move of the robot in the requested direction.
- Checks the target cell against the maze wall map, which is a synchronous ROM with 1-cycle read latency.
- Holds the authoritative robot position, which feeds the VGA draw stage and the win/collision logic.

Parameters:
- GRID_W, 160, maze width in cells (x range 0..GRID_W-1)
- GRID_H, 120, maze height in cells (y range 0..GRID_H-1)
- X_W, 8, width of pos_x
- Y_W, 7, width of pos_y
- ADDR_W, 15, wall-map address width (GRID_W*GRID_H = 19200 cells)
- START_X, 1, reset x position
- START_Y, 1, reset y position

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle move-rate pulse from the limiter
- dir  in  4  one-hot request {up,down,left,right} = dir[3:0], active-high
- map_addr  out  ADDR_W  wall-map read address
- map_data  in  1  wall bit for the address presented last cycle; 1 = wall
- pos_x  out  X_W  current robot x
- pos_y  out  Y_W  current robot y
- busy  out  1  high while a move is in flight
- moved  out  1  one-cycle pulse: position updated
- blocked  out  1  one-cycle pulse: move rejected (wall or grid edge)

Behaviour:
- Interface (already decided): one clock, `clock`. Reset `reset` is synchronous and active-high; it is sampled only on posedge clock.
- Reset values:
  - pos_x = START_X, pos_y = START_Y
  - map_addr = 0
  - busy = 0, moved = 0, blocked = 0
  - state = IDLE
- Reset has priority over everything. A reset asserted mid-move (FETCH or CHECK) abandons the move with no moved/blocked pulse; the next cycle is IDLE at the start position.
- States: IDLE, FETCH, CHECK. All outputs are registered.
- IDLE:
  - Acts only when tick = 1 and dir has exactly one bit set. A tick with dir = 0 or more than one bit set is ignored.
  - Target cell: up = y-1, down = y+1, left = x-1, right = x+1.
  - If the target is outside the grid (x=0 left, x=GRID_W-1 right, y=0 up, y=GRID_H-1 down): blocked=1 next cycle, stay IDLE, map_addr unchanged. No wrap-around ever occurs.
  - Otherwise latch tx/ty, register map_addr = ty*GRID_W + tx (ADDR_W bits, computed at full width, no truncation for in-grid cells), go to FETCH.
- FETCH: busy=1, map_addr held; the ROM samples the address at the end of this cycle.
- CHECK: busy=1, map_data valid.
  - map_data = 0: pos <= (tx,ty), moved=1 next cycle.
  - map_data = 1: pos unchanged, blocked=1 next cycle.
  - Always return to IDLE.
- Latency, with tick accepted in cycle T:
  - map_addr valid and busy=1 in T+1..T+2
  - new pos and moved/blocked visible in T+3
  - a new tick is accepted from T+3
- A tick arriving while busy (T+1, T+2) is dropped, not queued.
- moved and blocked are never high together and never longer than 1 cycle. pos changes only coincident with moved.
- dir is sampled only in the IDLE tick cycle; dir changes during FETCH/CHECK have no effect.

Decomposition:
- Package robo_pkg holds:
  - GRID_W, GRID_H, ADDR_W
  - direction bit indices DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0
  - mover state encoding (IDLE, FETCH, CHECK)
  - shared by the limiter, draw and collision stages.
- Sub-module cell_addr (combinational x,y -> y*GRID_W+x) is natural, because the VGA draw stage reuses the same mapping. Everything else stays in one module.

Test Plan:
- Reset -> pos=(1,1), busy/moved/blocked=0; hold reset 3 cycles with ticks -> no change.
- pos (10,10), dir=0001, tick at T, map_data=0 -> map_addr=1611 in T+1..T+2, busy high T+1..T+2, pos=(11,10) and moved=1 in T+3 only.
- pos (10,10), dir=1000, map_data=1 -> map_addr=1450, blocked=1 in T+3, pos stays (10,10), moved stays 0.
- pos (0,5), dir=0010 tick -> blocked=1 in T+1, state stays IDLE, map_addr unchanged; pos (159,119), dir=0101 (two bits) tick -> no pulse, no change.
- Tick in T, second tick in T+1 and T+2 -> exactly one move completes; tick in T+3 starts a new move (map_addr updates in T+4).
- Move started in T, reset asserted in T+2 -> T+3 shows pos=(1,1), moved=0, blocked=0, busy=0.
